xdma_dsc_byp_arbiter: RTL and testbench



---
 rtl/xdma_dsc_byp_arbiter_pkg.sv | 55 +++++
 rtl/xdma_dsc_byp_arbiter_if.sv | 47 ++++
 rtl/xdma_dsc_byp_arbiter_rr_arbiter.sv | 44 ++++
 rtl/xdma_dsc_byp_arbiter.sv | 163 ++++++++++++++++
 tb/tb_xdma_dsc_byp_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/xdma_dsc_byp_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : xdma_byp_pkg
// Purpose  : Shared widths, descriptor control bit positions, descriptor
//            record type, FSM state encoding and chunking helpers for the
//            XDMA descriptor-bypass arbiter.
// Ports    : none (package)
// Options  : XDMA_BYP_STATS_EN (used by xdma_dsc_byp_arbiter, not here)
// Revision : 1.0 - initial release
// ============================================================================
package xdma_byp_pkg;

  localparam int DSC_ADDR_W = 64;
  localparam int DSC_LEN_W  = 28;
  localparam int DSC_CTL_W  = 16;

  // Descriptor control bit positions
  localparam int CTL_STOP = 0;
  localparam int CTL_CMPL = 1;
  localparam int CTL_EOP  = 4;

  typedef struct packed {
    logic [DSC_ADDR_W-1:0] src;
    logic [DSC_ADDR_W-1:0] dst;
    logic [DSC_LEN_W-1:0]  len;
  } dsc_t;

  typedef enum logic [0:0] {
    FSM_IDLE  = 1'b0,
    FSM_ISSUE = 1'b1
  } fsm_state_e;

  // Length of the next descriptor carved from the remaining byte count.
  function automatic logic [DSC_LEN_W-1:0] chunk_len(
    input logic [DSC_LEN_W-1:0] remaining,
    input logic [DSC_LEN_W-1:0] max_chunk
  );
    return (remaining > max_chunk) ? max_chunk : remaining;
  endfunction

  // Control word: EOP and (optionally) COMPLETED only on the final chunk.
  function automatic logic [DSC_CTL_W-1:0] chunk_ctl(
    input logic is_last,
    input logic cmpl_on_last
  );
    logic [DSC_CTL_W-1:0] ctl;
    ctl           = '0;
    ctl[CTL_STOP] = 1'b0;
    ctl[CTL_CMPL] = is_last & cmpl_on_last;
    ctl[CTL_EOP]  = is_last;
    return ctl;
  endfunction

endpackage
`default_nettype wire

// File: rtl/xdma_dsc_byp_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : xdma_dsc_byp_arbiter_if
// Purpose  : Bundles the requester-side request/ready/done/err signals and
//            the XDMA *_dsc_byp_* descriptor port into one interface.
// Modports : master - requesters + XDMA core side (drives req_*, dsc_byp_ready)
//            slave  - the arbiter (drives req_ready/done/err, dsc_byp_*)
// Ports    : NUM_REQ-wide req_valid/req_ready/req_done/req_err,
//            packed req_src_addr/req_dst_addr (64b each), req_len (28b each),
//            dsc_byp_load/src_addr/dst_addr/len/ctl, dsc_byp_ready
// Revision : 1.0 - initial release
// ============================================================================
interface xdma_dsc_byp_arbiter_if
  import xdma_byp_pkg::*;
#(
  parameter int NUM_REQ = 4
);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*DSC_ADDR_W-1:0] req_src_addr;
  logic [NUM_REQ*DSC_ADDR_W-1:0] req_dst_addr;
  logic [NUM_REQ*DSC_LEN_W-1:0]  req_len;
  logic [NUM_REQ-1:0]            req_done;
  logic [NUM_REQ-1:0]            req_err;

  logic                          dsc_byp_load;
  logic [DSC_ADDR_W-1:0]         dsc_byp_src_addr;
  logic [DSC_ADDR_W-1:0]         dsc_byp_dst_addr;
  logic [DSC_LEN_W-1:0]          dsc_byp_len;
  logic [DSC_CTL_W-1:0]          dsc_byp_ctl;
  logic                          dsc_byp_ready;

  modport master (
    output req_valid, req_src_addr, req_dst_addr, req_len, dsc_byp_ready,
    input  req_ready, req_done, req_err,
           dsc_byp_load, dsc_byp_src_addr, dsc_byp_dst_addr, dsc_byp_len, dsc_byp_ctl
  );

  modport slave (
    input  req_valid, req_src_addr, req_dst_addr, req_len, dsc_byp_ready,
    output req_ready, req_done, req_err,
           dsc_byp_load, dsc_byp_src_addr, dsc_byp_dst_addr, dsc_byp_len, dsc_byp_ctl
  );

endinterface
`default_nettype wire

// File: rtl/xdma_dsc_byp_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin pick: the first requesting index
//            after last_grant (wrapping). The one-hot grant is only driven
//            while update_en is high, i.e. in the cycle the caller will
//            record the new pointer.
// Ports    : req[NUM_REQ] in, last_grant in, update_en in,
//            grant[NUM_REQ] one-hot out, grant_idx out, grant_valid out
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  input  logic               update_en,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid
);

  always_comb begin
    logic found;
    int   cand;
    found     = 1'b0;
    cand      = 0;
    grant     = '0;
    grant_idx = last_grant;
    // Offset 1 first so the most recently served requester is tried last.
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = (int'(last_grant) + off) % NUM_REQ;
      if (!found && req[cand]) begin
        found     = 1'b1;
        grant_idx = IDX_W'(cand);
      end
    end
    grant_valid = found & update_en;
    if (grant_valid) grant[grant_idx] = 1'b1;
  end

endmodule
`default_nettype wire

// File: rtl/xdma_dsc_byp_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : xdma_dsc_byp_arbiter
// Purpose  : Shares one XDMA descriptor-bypass channel between NUM_REQ
//            requesters. Round-robin accept, latch the winning request, then
//            issue it as successive descriptors of at most MAX_CHUNK bytes.
// Ports    : axi_aclk, axi_areset (sync, active-high)
//            bus (slave modport): req_valid/ready/done/err, req_src/dst/len,
//                                 dsc_byp_load/src/dst/len/ctl, dsc_byp_ready
//            stat_dsc_cnt, stat_req_cnt (only with XDMA_BYP_STATS_EN)
// Options  : XDMA_BYP_STATS_EN - adds load-cycle and done-pulse counters
// Revision : 1.0 - initial release
// ============================================================================
module xdma_dsc_byp_arbiter
  import xdma_byp_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int MAX_CHUNK    = 4096,
  parameter int CMPL_ON_LAST = 1
) (
  input  logic                 axi_aclk,
  input  logic                 axi_areset,
  xdma_dsc_byp_arbiter_if.slave bus
`ifdef XDMA_BYP_STATS_EN
  ,
  output logic [31:0]          stat_dsc_cnt,
  output logic [31:0]          stat_req_cnt
`endif
);

  localparam int                    IDX_W   = $clog2(NUM_REQ);
  localparam logic [DSC_LEN_W-1:0]  CHUNK   = DSC_LEN_W'(MAX_CHUNK);
  localparam logic [DSC_ADDR_W-1:0] CHUNK_A = DSC_ADDR_W'(MAX_CHUNK);
  localparam logic                  CMPL    = (CMPL_ON_LAST != 0);

  localparam logic [0:0] IDLE  = FSM_IDLE;
  localparam logic [0:0] ISSUE = FSM_ISSUE;

  logic [0:0]           state;
  logic [IDX_W-1:0]     last_grant;
  logic [IDX_W-1:0]     owner;
  dsc_t                 cur;       // cur.len holds the bytes still to issue
  logic [DSC_LEN_W-1:0] len_q;
  logic [DSC_CTL_W-1:0] ctl_q;
  logic [NUM_REQ-1:0]   err_q;

  logic [DSC_ADDR_W-1:0] src_a [NUM_REQ];
  logic [DSC_ADDR_W-1:0] dst_a [NUM_REQ];
  logic [DSC_LEN_W-1:0]  len_a [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign src_a[i] = bus.req_src_addr[i*DSC_ADDR_W +: DSC_ADDR_W];
    assign dst_a[i] = bus.req_dst_addr[i*DSC_ADDR_W +: DSC_ADDR_W];
    assign len_a[i] = bus.req_len[i*DSC_LEN_W +: DSC_LEN_W];
  end

  logic                 arb_en;
  logic [NUM_REQ-1:0]   grant;
  logic [IDX_W-1:0]     grant_idx;
  logic                 grant_valid;
  logic [DSC_LEN_W-1:0] sel_len;
  logic                 load;
  logic                 last_chunk;
  logic [DSC_LEN_W-1:0] rem_next;
  logic [NUM_REQ-1:0]   done_oh;

  // Handshakes are masked during reset so nothing is accepted or loaded in
  // a cycle whose state is about to be discarded.
  assign arb_en = (state == IDLE) && !axi_areset;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req         (bus.req_valid),
    .last_grant  (last_grant),
    .update_en   (arb_en),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign sel_len    = len_a[grant_idx];
  assign load       = (state == ISSUE) && bus.dsc_byp_ready && !axi_areset;
  assign last_chunk = (cur.len <= CHUNK);
  assign rem_next   = cur.len - CHUNK;

  always_comb begin
    done_oh = '0;
    if (load && last_chunk) done_oh[owner] = 1'b1;
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      state      <= IDLE;
      last_grant <= IDX_W'(NUM_REQ - 1);
      owner      <= '0;
      cur        <= '0;
      len_q      <= '0;
      ctl_q      <= '0;
      err_q      <= '0;
    end else begin
      err_q <= '0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            last_grant <= grant_idx;
            owner      <= grant_idx;
            if (sel_len == '0) begin
              err_q <= grant;
            end else begin
              cur.src <= src_a[grant_idx];
              cur.dst <= dst_a[grant_idx];
              cur.len <= sel_len;
              len_q   <= chunk_len(sel_len, CHUNK);
              ctl_q   <= chunk_ctl(sel_len <= CHUNK, CMPL);
              state   <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (load) begin
            if (last_chunk) begin
              state <= IDLE;
              cur   <= '0;
              len_q <= '0;
              ctl_q <= '0;
            end else begin
              cur.src <= cur.src + CHUNK_A;
              cur.dst <= cur.dst + CHUNK_A;
              cur.len <= rem_next;
              len_q   <= chunk_len(rem_next, CHUNK);
              ctl_q   <= chunk_ctl(rem_next <= CHUNK, CMPL);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready        = grant;
  assign bus.req_done         = done_oh;
  assign bus.req_err          = err_q;
  assign bus.dsc_byp_load     = load;
  assign bus.dsc_byp_src_addr = cur.src;
  assign bus.dsc_byp_dst_addr = cur.dst;
  assign bus.dsc_byp_len      = len_q;
  assign bus.dsc_byp_ctl      = ctl_q;

`ifdef XDMA_BYP_STATS_EN
  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      stat_dsc_cnt <= '0;
      stat_req_cnt <= '0;
    end else begin
      if (load)               stat_dsc_cnt <= stat_dsc_cnt + 32'd1;
      if (load && last_chunk) stat_req_cnt <= stat_req_cnt + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_xdma_dsc_byp_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_xdma_dsc_byp_arbiter
// Purpose  : Self-checking bench for xdma_dsc_byp_arbiter. Requests are
//            tracked at transaction level: each accepted request is expanded
//            into its list of expected descriptors, and grants are predicted
//            from the round-robin rule.
// Options  : XDMA_BYP_STATS_EN - also checks the statistics counters
// Revision : 1.0 - initial release
// ============================================================================
module tb_xdma_dsc_byp_arbiter;
  import xdma_byp_pkg::*;

  localparam int NUM_REQ      = 4;
  localparam int MAX_CHUNK    = 4096;
  localparam int CMPL_ON_LAST = 1;

  logic axi_aclk   = 1'b0;
  logic axi_areset = 1'b1;
  always #5 axi_aclk = ~axi_aclk;

  xdma_dsc_byp_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

`ifdef XDMA_BYP_STATS_EN
  logic [31:0] stat_dsc_cnt;
  logic [31:0] stat_req_cnt;
`endif

  xdma_dsc_byp_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .MAX_CHUNK    (MAX_CHUNK),
    .CMPL_ON_LAST (CMPL_ON_LAST)
  ) dut (
    .axi_aclk     (axi_aclk),
    .axi_areset   (axi_areset),
    .bus          (bus)
`ifdef XDMA_BYP_STATS_EN
    ,
    .stat_dsc_cnt (stat_dsc_cnt),
    .stat_req_cnt (stat_req_cnt)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Requester-side pending requests (one outstanding per requester)
  bit          pend_v   [NUM_REQ];
  logic [63:0] pend_src [NUM_REQ];
  logic [63:0] pend_dst [NUM_REQ];
  logic [27:0] pend_len [NUM_REQ];

  int valid_pct     = 100;
  int ready_pct     = 100;
  int ready_low_cnt = 0;
  logic [NUM_REQ-1:0] drv_valid = '0;
  logic               drv_ready = 1'b0;

  // Reference model state
  typedef struct {
    logic [63:0] src;
    logic [63:0] dst;
    logic [27:0] len;
    logic [15:0] ctl;
    int          owner;
    bit          last;
  } chunk_t;

  chunk_t             exp_q[$];
  int                 m_last   = NUM_REQ - 1;
  logic [NUM_REQ-1:0] m_err    = '0;
  int                 accepted = -1;
  int                 grant_log[$];
  int                 loads = 0;
  int                 dones = 0;

  task automatic set_req(input int i, input logic [63:0] s, input logic [63:0] d, input logic [27:0] l);
    pend_v[i]   = 1'b1;
    pend_src[i] = s;
    pend_dst[i] = d;
    pend_len[i] = l;
  endtask

  task automatic drive_inputs();
    if (accepted >= 0) pend_v[accepted] = 1'b0;
    accepted = -1;
    for (int i = 0; i < NUM_REQ; i++) begin
      drv_valid[i] = pend_v[i] && ($urandom_range(99) < valid_pct);
      if (pend_v[i]) begin
        bus.req_src_addr[i*64 +: 64] = pend_src[i];
        bus.req_dst_addr[i*64 +: 64] = pend_dst[i];
        bus.req_len[i*28 +: 28]      = pend_len[i];
      end else begin
        bus.req_src_addr[i*64 +: 64] = {$urandom, $urandom};
        bus.req_dst_addr[i*64 +: 64] = {$urandom, $urandom};
        bus.req_len[i*28 +: 28]      = 28'($urandom);
      end
    end
    bus.req_valid = drv_valid;
    if (ready_low_cnt > 0) begin
      drv_ready = 1'b0;
      ready_low_cnt--;
    end else begin
      drv_ready = ($urandom_range(99) < ready_pct);
    end
    bus.dsc_byp_ready = drv_ready;
  endtask

  task automatic push_chunks(input int g);
    int n;
    n = (int'(pend_len[g]) + MAX_CHUNK - 1) / MAX_CHUNK;
    for (int k = 0; k < n; k++) begin
      chunk_t c;
      c.src   = pend_src[g] + 64'(k) * 64'(MAX_CHUNK);
      c.dst   = pend_dst[g] + 64'(k) * 64'(MAX_CHUNK);
      c.last  = (k == n - 1);
      c.len   = c.last ? 28'(int'(pend_len[g]) - (n - 1) * MAX_CHUNK) : 28'(MAX_CHUNK);
      c.ctl   = c.last ? (16'h0010 | ((CMPL_ON_LAST != 0) ? 16'h0002 : 16'h0000)) : 16'h0000;
      c.owner = g;
      exp_q.push_back(c);
    end
  endtask

  task automatic check_cycle();
    logic [NUM_REQ-1:0] exp_ready;
    logic [NUM_REQ-1:0] exp_done;
    int g;
    exp_ready = '0;
    exp_done  = '0;
    g         = -1;
    if (exp_q.size() == 0) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        int c;
        c = (m_last + k) % NUM_REQ;
        if (g < 0 && drv_valid[c]) g = c;
      end
    end
    if (g >= 0) exp_ready[g] = 1'b1;
    check_val("req_ready", bus.req_ready, exp_ready);
    check_val("req_err", bus.req_err, m_err);
    m_err = '0;
    if (exp_q.size() > 0) begin
      chunk_t h;
      h = exp_q[0];
      check_val("dsc_byp_load", bus.dsc_byp_load, drv_ready);
      check_val("dsc_src", bus.dsc_byp_src_addr, h.src);
      check_val("dsc_dst", bus.dsc_byp_dst_addr, h.dst);
      check_val("dsc_len", bus.dsc_byp_len, h.len);
      check_val("dsc_ctl", bus.dsc_byp_ctl, h.ctl);
      if (drv_ready) begin
        loads++;
        if (h.last) begin
          exp_done[h.owner] = 1'b1;
          dones++;
        end
        void'(exp_q.pop_front());
      end
    end else begin
      check_val("dsc_byp_load_idle", bus.dsc_byp_load, 1'b0);
    end
    check_val("req_done", bus.req_done, exp_done);
    if (g >= 0) begin
      accepted = g;
      m_last   = g;
      grant_log.push_back(g);
      if (pend_len[g] == 28'd0) m_err[g] = 1'b1;
      else push_chunks(g);
    end
  endtask

  task automatic step();
    @(posedge axi_aclk);
    #1;
    drive_inputs();
    @(negedge axi_aclk);
    check_cycle();
  endtask

  function automatic bit all_quiet();
    bit q;
    q = (exp_q.size() == 0) && (m_err == '0) && (accepted < 0);
    for (int i = 0; i < NUM_REQ; i++) if (pend_v[i]) q = 1'b0;
    return q;
  endfunction

  task automatic drain(input string tag, input int max_cycles);
    int n;
    n = 0;
    while (!all_quiet() && n < max_cycles) begin
      step();
      n++;
    end
    check_val(tag, 64'(all_quiet()), 64'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_ready"}, bus.req_ready, '0);
    check_val({tag, "_done"},  bus.req_done, '0);
    check_val({tag, "_err"},   bus.req_err, '0);
    check_val({tag, "_load"},  bus.dsc_byp_load, 1'b0);
    check_val({tag, "_src"},   bus.dsc_byp_src_addr, 64'd0);
    check_val({tag, "_dst"},   bus.dsc_byp_dst_addr, 64'd0);
    check_val({tag, "_len"},   bus.dsc_byp_len, 64'd0);
    check_val({tag, "_ctl"},   bus.dsc_byp_ctl, 64'd0);
  endtask

  initial begin
    int l0, d0, first_last, loads_at_rst, dones_at_rst, wait_n;
    for (int i = 0; i < NUM_REQ; i++) pend_v[i] = 1'b0;
    bus.req_valid     = '0;
    bus.req_src_addr  = '0;
    bus.req_dst_addr  = '0;
    bus.req_len       = '0;
    bus.dsc_byp_ready = 1'b0;

    // Reset values
    repeat (3) @(posedge axi_aclk);
    @(negedge axi_aclk);
    check_all_zero("reset");
    @(posedge axi_aclk);
    #1;
    axi_areset = 1'b0;

    // Single short request on requester 0
    l0 = loads; d0 = dones;
    set_req(0, 64'h0000_0001_0000_0000, 64'h0000_0002_0000_0000, 28'h100);
    drain("single_drain", 20);
    check_val("single_loads", 64'(loads - l0), 64'd1);
    check_val("single_dones", 64'(dones - d0), 64'd1);

    // 10000 bytes on requester 1 -> three descriptors
    l0 = loads; d0 = dones;
    set_req(1, 64'h0000_0000_1234_0000, 64'h0000_0000_5678_0000, 28'd10000);
    drain("split_drain", 30);
    check_val("split_loads", 64'(loads - l0), 64'd3);
    check_val("split_dones", 64'(dones - d0), 64'd1);

    // All four requesters at once: rotating order from last grant
    grant_log.delete();
    first_last = m_last;
    for (int i = 0; i < NUM_REQ; i++)
      set_req(i, 64'(i) << 20, 64'(i) << 24, 28'd64);
    drain("all4_drain", 40);
    check_val("all4_grants", 64'(grant_log.size()), 64'(NUM_REQ));
    for (int k = 0; k < NUM_REQ && k < grant_log.size(); k++)
      check_val("all4_order", 64'(grant_log[k]), 64'((first_last + 1 + k) % NUM_REQ));

    // Back-pressure: ready low through the accept cycle plus five issue cycles
    l0 = loads;
    set_req(3, 64'hDEAD_0000_0000_0000, 64'hBEEF_0000_0000_0000, 28'h80);
    ready_low_cnt = 6;
    drain("bp_drain", 20);
    check_val("bp_loads", 64'(loads - l0), 64'd1);

    // Zero-length request on requester 2
    l0 = loads;
    set_req(2, 64'h10, 64'h20, 28'd0);
    drain("zero_drain", 10);
    check_val("zero_loads", 64'(loads - l0), 64'd0);

    // Address wrap at 2^64
    set_req(0, 64'hFFFF_FFFF_FFFF_F800, 64'hFFFF_FFFF_FFFF_F000, 28'd9000);
    drain("wrap_drain", 30);

    // Reset after the first of three chunks
    l0 = loads; d0 = dones;
    set_req(1, 64'h4000_0000, 64'h8000_0000, 28'(3 * MAX_CHUNK));
    wait_n = 0;
    while (loads == l0 && wait_n < 20) begin
      step();
      wait_n++;
    end
    check_val("mid_first_load", 64'(loads - l0), 64'd1);
    @(posedge axi_aclk);
    #1;
    axi_areset = 1'b1;
    @(negedge axi_aclk);
    check_val("mid_rst_done", bus.req_done, '0);
    @(posedge axi_aclk);
    #1;
    for (int i = 0; i < NUM_REQ; i++) pend_v[i] = 1'b0;
    drv_valid     = '0;
    bus.req_valid = '0;
    exp_q.delete();
    m_last   = NUM_REQ - 1;
    m_err    = '0;
    accepted = -1;
    @(negedge axi_aclk);
    check_all_zero("mid_rst");
    @(posedge axi_aclk);
    #1;
    axi_areset   = 1'b0;
    loads_at_rst = loads;
    dones_at_rst = dones;
    grant_log.delete();
    set_req(1, 64'h100, 64'h200, 28'd32);
    set_req(0, 64'h300, 64'h400, 28'd32);
    drain("post_rst_drain", 20);
    check_val("post_rst_first", 64'((grant_log.size() > 0) ? grant_log[0] : -1), 64'd0);

    // Randomized traffic
    valid_pct = 70;
    ready_pct = 75;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!pend_v[i] && $urandom_range(99) < 20) begin
          logic [27:0] l;
          case ($urandom_range(7))
            0:       l = 28'd0;
            1:       l = 28'(MAX_CHUNK);
            2:       l = 28'(MAX_CHUNK + 1);
            3:       l = 28'($urandom_range(256, 1));
            4:       l = 28'($urandom_range(4 * MAX_CHUNK, 1));
            default: l = 28'($urandom_range(3 * MAX_CHUNK, 1));
          endcase
          if ($urandom_range(9) == 0)
            set_req(i, 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(8192)), {$urandom, $urandom}, l);
          else
            set_req(i, {$urandom, $urandom}, {$urandom, $urandom}, l);
        end
      end
      step();
    end
    valid_pct = 100;
    ready_pct = 100;
    drain("rand_drain", 200);

`ifdef XDMA_BYP_STATS_EN
    check_val("stat_dsc_cnt", stat_dsc_cnt, 64'(loads - loads_at_rst));
    check_val("stat_req_cnt", stat_req_cnt, 64'(dones - dones_at_rst));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
